// File: rtl/soc_sram_resp_if.sv
`default_nettype none
// ============================================================================
// Module      : soc_sram_resp_if
// Description : Bundle of the instruction-port and data-port SRAM request /
//               response signals. The master drives requests and samples
//               rdata/err; the slave (the SRAM) does the opposite.
// Revision    : 1.0 - initial release
// ============================================================================
interface soc_sram_resp_if;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        inst_sram_err;

    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        data_sram_err;

    modport master (
        output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        input  inst_sram_rdata, inst_sram_err,
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata, data_sram_err
    );

    modport slave (
        input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        output inst_sram_rdata, inst_sram_err,
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output data_sram_rdata, data_sram_err
    );
endinterface
`default_nettype wire

// File: rtl/soc_sram_resp.sv
`default_nettype none
// ============================================================================
// Module      : soc_sram_resp
// Description : Dual-port (instruction + data) 32-bit word SRAM with byte
//               enables, one-cycle registered read-first responses and an
//               out-of-window error pulse. Memory contents survive reset.
//               Optional macro SRAM_RDW_FWD_EN: a port reading a word that the
//               other port writes in the same cycle sees the merged new data
//               on the lanes the other port writes.
// Revision    : 1.0 - initial release
// ============================================================================
module soc_sram_resp #(
    parameter int          ADDR_W = 14,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    soc_sram_resp_if.slave   bus
);

    localparam int          c_depth     = 1 << ADDR_W;
    localparam logic [32:0] c_win_bytes = 33'd4 << ADDR_W;

    logic [31:0]       r_mem [0:c_depth-1];

    logic [31:0]       r_inst_rdata;
    logic              r_inst_err;
    logic [31:0]       r_data_rdata;
    logic              r_data_err;

    logic [31:0]       w_inst_off;
    logic [31:0]       w_data_off;
    logic              w_inst_hit;
    logic              w_data_hit;
    logic [ADDR_W-1:0] w_inst_idx;
    logic [ADDR_W-1:0] w_data_idx;
    logic              w_inst_wr;
    logic              w_data_wr;
    logic              w_same_word;
    logic [31:0]       w_inst_old;
    logic [31:0]       w_data_old;
    logic [31:0]       w_inst_rd;
    logic [31:0]       w_data_rd;

    // Offset from BASE; an address below BASE wraps to a huge offset and
    // therefore falls outside the window as well.
    assign w_inst_off  = bus.inst_sram_addr - BASE;
    assign w_data_off  = bus.data_sram_addr - BASE;
    assign w_inst_hit  = ({1'b0, w_inst_off} < c_win_bytes);
    assign w_data_hit  = ({1'b0, w_data_off} < c_win_bytes);
    assign w_inst_idx  = w_inst_off[ADDR_W+1:2];
    assign w_data_idx  = w_data_off[ADDR_W+1:2];

    // Writes are blocked during reset and for out-of-window requests.
    assign w_inst_wr   = bus.inst_sram_en & ~rst & w_inst_hit & (|bus.inst_sram_wen);
    assign w_data_wr   = bus.data_sram_en & ~rst & w_data_hit & (|bus.data_sram_wen);
    assign w_same_word = (w_inst_idx == w_data_idx);

    assign w_inst_old  = r_mem[w_inst_idx];
    assign w_data_old  = r_mem[w_data_idx];

`ifdef SRAM_RDW_FWD_EN
    // Each reader sees, on lanes the other port writes this cycle, the final
    // value stored there (data port wins a shared lane); own lanes read-first.
    always_comb begin
        w_inst_rd = w_inst_old;
        w_data_rd = w_data_old;
        for (int b = 0; b < 4; b++) begin
            if (w_data_wr && w_same_word && bus.data_sram_wen[b]) begin
                w_inst_rd[8*b +: 8] = bus.data_sram_wdata[8*b +: 8];
            end
            if (w_inst_wr && w_same_word && bus.inst_sram_wen[b]) begin
                if (w_data_wr && bus.data_sram_wen[b]) begin
                    w_data_rd[8*b +: 8] = bus.data_sram_wdata[8*b +: 8];
                end else begin
                    w_data_rd[8*b +: 8] = bus.inst_sram_wdata[8*b +: 8];
                end
            end
        end
    end
`else
    // Plain read-first on both ports, even for cross-port collisions.
    assign w_inst_rd = w_inst_old;
    assign w_data_rd = w_data_old;
`endif

    // Byte-lane writes; data port is applied last so it wins shared lanes.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_inst_wr && bus.inst_sram_wen[b]) begin
                r_mem[w_inst_idx][8*b +: 8] <= bus.inst_sram_wdata[8*b +: 8];
            end
            if (w_data_wr && bus.data_sram_wen[b]) begin
                r_mem[w_data_idx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
            end
        end
    end

    // Instruction-port response: data/zero+err one cycle after a request, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst_rdata <= 32'd0;
            r_inst_err   <= 1'b0;
        end else begin
            r_inst_err <= 1'b0;
            if (bus.inst_sram_en) begin
                if (w_inst_hit) begin
                    r_inst_rdata <= w_inst_rd;
                end else begin
                    r_inst_rdata <= 32'd0;
                    r_inst_err   <= 1'b1;
                end
            end
        end
    end

    // Data-port response: same behaviour as the instruction port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_rdata <= 32'd0;
            r_data_err   <= 1'b0;
        end else begin
            r_data_err <= 1'b0;
            if (bus.data_sram_en) begin
                if (w_data_hit) begin
                    r_data_rdata <= w_data_rd;
                end else begin
                    r_data_rdata <= 32'd0;
                    r_data_err   <= 1'b1;
                end
            end
        end
    end

    assign bus.inst_sram_rdata = r_inst_rdata;
    assign bus.inst_sram_err   = r_inst_err;
    assign bus.data_sram_rdata = r_data_rdata;
    assign bus.data_sram_err   = r_data_err;

endmodule
`default_nettype wire

// File: tb/tb_soc_sram_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_soc_sram_resp
// Description : Directed self-checking bench for soc_sram_resp with
//               hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_sram_resp;

    localparam int          c_addr_w = 8;
    localparam logic [31:0] c_base   = 32'h8000_0000;
    localparam logic [31:0] c_top    = c_base + (32'd4 << c_addr_w);

    logic clk;
    logic rst;
    int   r_tests;
    int   r_fails;

    soc_sram_resp_if bus ();

    soc_sram_resp #(
        .ADDR_W (c_addr_w),
        .BASE   (c_base)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        r_tests++;
        if (act !== exp) begin
            r_fails++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic inst_req(input logic en, input logic [3:0] wen,
                            input logic [31:0] addr, input logic [31:0] wdata);
        bus.inst_sram_en    = en;
        bus.inst_sram_wen   = wen;
        bus.inst_sram_addr  = addr;
        bus.inst_sram_wdata = wdata;
    endtask

    task automatic data_req(input logic en, input logic [3:0] wen,
                            input logic [31:0] addr, input logic [31:0] wdata);
        bus.data_sram_en    = en;
        bus.data_sram_wen   = wen;
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = wdata;
    endtask

    task automatic idle();
        inst_req(1'b0, 4'h0, 32'h0, 32'h0);
        data_req(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        r_tests = 0;
        r_fails = 0;
        rst     = 1'b1;
        idle();
        cyc();
        cyc();
        check("rst_inst_rdata", bus.inst_sram_rdata, 32'h0);
        check("rst_inst_err",   {31'd0, bus.inst_sram_err}, 32'h0);
        check("rst_data_rdata", bus.data_sram_rdata, 32'h0);
        check("rst_data_err",   {31'd0, bus.data_sram_err}, 32'h0);
        rst = 1'b0;

        // Clear word 0 and word 3 so later collision cases start from 0.
        data_req(1'b1, 4'hF, c_base + 32'h0, 32'h0);
        inst_req(1'b1, 4'hF, c_base + 32'hC, 32'h0);
        cyc();

        // Full write then read one cycle later.
        data_req(1'b1, 4'hF, c_base + 32'h8, 32'h1234_5678);
        inst_req(1'b0, 4'h0, 32'h0, 32'h0);
        cyc();
        data_req(1'b1, 4'h0, c_base + 32'h8, 32'h0);
        cyc();
        check("wr_rd_b8", bus.data_sram_rdata, 32'h1234_5678);
        check("wr_rd_b8_err", {31'd0, bus.data_sram_err}, 32'h0);

        // Byte-lane partial write; response to the write itself is read-first.
        data_req(1'b1, 4'hF, c_base + 32'h4, 32'hAABB_CCDD);
        cyc();
        data_req(1'b1, 4'b0101, c_base + 32'h5, 32'h1122_3344);
        cyc();
        check("read_first", bus.data_sram_rdata, 32'hAABB_CCDD);
        data_req(1'b1, 4'h0, c_base + 32'h7, 32'h0);
        cyc();
        check("byte_lanes", bus.data_sram_rdata, 32'hAA22_CC44);

        // Hold with en=0.
        idle();
        cyc();
        check("hold_rdata", bus.data_sram_rdata, 32'hAA22_CC44);

        // Out-of-window write just past the top (would alias word 0) and
        // inst read just below BASE.
        data_req(1'b1, 4'hF, c_top, 32'hDEAD_DEAD);
        inst_req(1'b1, 4'h0, c_base - 32'h4, 32'h0);
        cyc();
        check("oow_data_err",   {31'd0, bus.data_sram_err}, 32'h1);
        check("oow_data_rdata", bus.data_sram_rdata, 32'h0);
        check("oow_inst_err",   {31'd0, bus.inst_sram_err}, 32'h1);
        idle();
        cyc();
        check("oow_err_pulse", {31'd0, bus.data_sram_err}, 32'h0);
        data_req(1'b1, 4'h0, c_base, 32'h0);
        inst_req(1'b1, 4'h0, c_top - 32'h4, 32'h0);
        cyc();
        check("oow_mem_kept", bus.data_sram_rdata, 32'h0);
        check("top_word_err", {31'd0, bus.inst_sram_err}, 32'h0);

        // Independent ports, back-to-back, crossing words.
        inst_req(1'b1, 4'hF, c_base + 32'h10, 32'h55AA_55AA);
        data_req(1'b1, 4'hF, c_base + 32'h14, 32'h0102_0304);
        cyc();
        inst_req(1'b1, 4'h0, c_base + 32'h14, 32'h0);
        data_req(1'b1, 4'h0, c_base + 32'h10, 32'h0);
        cyc();
        check("indep_inst", bus.inst_sram_rdata, 32'h0102_0304);
        check("indep_data", bus.data_sram_rdata, 32'h55AA_55AA);

        // Same-word dual write: data wins shared lane 1.
        inst_req(1'b1, 4'b0011, c_base, 32'h0000_00FF);
        data_req(1'b1, 4'b0110, c_base, 32'hFFFF_0000);
        cyc();
        inst_req(1'b1, 4'h0, c_base, 32'h0);
        data_req(1'b1, 4'h0, c_base, 32'h0);
        cyc();
        check("dual_wr_data", bus.data_sram_rdata, 32'h00FF_00FF);
        check("dual_rd_inst", bus.inst_sram_rdata, 32'h00FF_00FF);

        // Cross-port read-during-write on word 3 (prior 0).
        inst_req(1'b1, 4'h0, c_base + 32'hC, 32'h0);
        data_req(1'b1, 4'hF, c_base + 32'hC, 32'hDEAD_BEEF);
        cyc();
`ifdef SRAM_RDW_FWD_EN
        check("rdw_cross", bus.inst_sram_rdata, 32'hDEAD_BEEF);
`else
        check("rdw_cross", bus.inst_sram_rdata, 32'h0);
`endif
        inst_req(1'b1, 4'h0, c_base + 32'hC, 32'h0);
        data_req(1'b0, 4'h0, 32'h0, 32'h0);
        cyc();
        check("rdw_after", bus.inst_sram_rdata, 32'hDEAD_BEEF);

        // Reset mid-stream with a pending write.
        data_req(1'b1, 4'hF, c_base + 32'h20, 32'hCAFE_F00D);
        inst_req(1'b0, 4'h0, 32'h0, 32'h0);
        cyc();
        data_req(1'b1, 4'h0, c_base + 32'h8, 32'h0);
        inst_req(1'b1, 4'h0, c_top + 32'h40, 32'h0);
        cyc();
        check("pre_rst_data", bus.data_sram_rdata, 32'h1234_5678);
        check("pre_rst_err",  {31'd0, bus.inst_sram_err}, 32'h1);
        rst = 1'b1;
        data_req(1'b1, 4'hF, c_base + 32'h20, 32'h0BAD_BEEF);
        inst_req(1'b1, 4'hF, c_base + 32'h8, 32'h0000_0000);
        cyc();
        check("mrst_data_rdata", bus.data_sram_rdata, 32'h0);
        check("mrst_inst_err",   {31'd0, bus.inst_sram_err}, 32'h0);
        rst = 1'b0;
        data_req(1'b1, 4'h0, c_base + 32'h20, 32'h0);
        inst_req(1'b1, 4'h0, c_base + 32'h8, 32'h0);
        cyc();
        check("mrst_no_write",   bus.data_sram_rdata, 32'hCAFE_F00D);
        check("mrst_no_write_i", bus.inst_sram_rdata, 32'h1234_5678);
        idle();
        cyc();

        $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/soc_sram_resp.md
SOC_SRAM_RESP -- requirements
Module: soc_sram_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning word-index width; depth = 2^ADDR_W 32-bit words.
REQ-002 SHALL have parameter BASE, default 32'h0000_0000, meaning byte address of word 0; BASE is aligned to 4*2^ADDR_W.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port inst_sram_en, input, 1, instruction-port request valid.
REQ-006 SHALL have port inst_sram_wen, input, 4, instruction-port byte write enables; bit i covers byte lane [8i+7:8i].
REQ-007 SHALL have port inst_sram_addr, input, 32, instruction-port byte address.
REQ-008 SHALL have port inst_sram_wdata, input, 32, instruction-port write data.
REQ-009 SHALL have port inst_sram_rdata, output, 32, instruction-port read data.
REQ-010 SHALL have port inst_sram_err, output, 1, instruction-port out-of-window flag.
REQ-011 SHALL have ports data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, data_sram_rdata and data_sram_err, same directions, widths and meanings as REQ-005..REQ-010, for the data port.

Function
REQ-012 SHALL accept a request on a port in every cycle that port's en=1; no stall or handshake beyond en.
REQ-013 SHALL ignore addr[1:0]; word index = (addr-BASE)>>2.
REQ-014 SHALL treat a request as in-window when BASE <= addr <= BASE+4*2^ADDR_W-1.
REQ-015 SHALL, for an in-window request with en=1, present the word's contents on rdata exactly one cycle after the request cycle.
REQ-016 SHALL be read-first on a single port: rdata for a request with wen!=0 is the word's contents before that write.
REQ-017 SHALL, at the clock edge of an in-window request with en=1, write wdata into each byte lane whose wen bit is 1 and leave other lanes unchanged.
REQ-018 SHALL hold rdata at its last value in cycles that follow an en=0 cycle.
REQ-019 SHALL, for an out-of-window request with en=1, suppress the write, drive rdata=0 and err=1 one cycle later.
REQ-020 SHALL keep err=0 in every cycle that does not follow an out-of-window request; err is a one-cycle pulse per request.
REQ-021 SHALL, when both ports write the same word in one cycle, apply data-port bytes on lanes both ports enable and each port's bytes on lanes only that port enables.
REQ-022 SHALL, when both ports read the same word in one cycle with no write, return identical data on both rdata outputs.
REQ-023 SHALL operate both ports fully independently on different words, including back-to-back accesses every cycle.

Reset
REQ-024 SHALL clear inst_sram_rdata, data_sram_rdata, inst_sram_err and data_sram_err to 0 in the cycle after any cycle with rst=1.
REQ-025 SHALL perform no write and produce no response for requests in cycles with rst=1, including a reset asserted mid-stream.
REQ-026 SHALL NOT initialise or clear memory contents on reset; contents survive reset.

Configuration
REQ-027 SHALL honour macro SRAM_RDW_FWD_EN.
REQ-028 SHALL, with SRAM_RDW_FWD_EN defined, return on a reading port the merged data when the other port writes the same in-window word in the same cycle: written lanes from the writer (data port winning per REQ-021), other lanes from prior contents.
REQ-029 SHALL, without SRAM_RDW_FWD_EN, return prior contents to the reading port in that cross-port case (read-first on both ports).

Verification
REQ-030 SHALL verify: data write addr=BASE+8, wen=4'hF, wdata=32'h1234_5678; next cycle read addr=BASE+8 -> data_sram_rdata=32'h1234_5678 one cycle later.
REQ-031 SHALL verify: word BASE+4 = 32'hAABB_CCDD, write wen=4'b0101 wdata=32'h1122_3344 -> subsequent read returns 32'hAA22_CC44.
REQ-032 SHALL verify: data read addr=BASE+4*2^ADDR_W -> data_sram_err=1 for one cycle, data_sram_rdata=0, memory unchanged.
REQ-033 SHALL verify: same cycle inst writes 32'h0000_00FF wen=4'b0011, data writes 32'hFFFF_0000 wen=4'b0110 to BASE+0 (prior 0) -> read returns 32'h00FF_00FF.
REQ-034 SHALL verify: word BASE+C = 32'h0; inst reads BASE+C while data writes 32'hDEAD_BEEF wen=4'hF there -> inst_sram_rdata=32'hDEAD_BEEF with SRAM_RDW_FWD_EN, 32'h0 without.
REQ-035 SHALL verify: write 32'hCAFE_F00D, assert rst one cycle with a pending write request -> outputs 0, pending write absent, prior word still reads 32'hCAFE_F00D.
